// File: rtl/uart_tx_multi.sv
// uart_tx_multi: word FIFO feeding a UART serialiser with runtime data width and 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the parity_i port and the PARITY frame state.
module uart_tx_multi #(
    parameter int BUFSZ                  = 2,
    parameter int CLOCKCYCLESPERBITLIMIT = 2,
    parameter int DATAWIDTH              = 8
) (
    input  logic                                      clk_i,
    input  logic                                      rst_i,
    input  logic [$clog2(CLOCKCYCLESPERBITLIMIT)-1:0] clockcyclesperbit_i,
    input  logic [3:0]                                databits_i,
    input  logic                                      stop2_i,
`ifdef UART_TX_PARITY_EN
    input  logic [1:0]                                parity_i,
`endif
    input  logic                                      push_i,
    input  logic [DATAWIDTH-1:0]                      data_i,
    output logic                                      full_o,
    output logic [$clog2(BUFSZ):0]                    usage_o,
    output logic                                      busy_o,
    output logic                                      tx_o
);
    localparam int CW = $clog2(CLOCKCYCLESPERBITLIMIT);
    localparam int AW = $clog2(BUFSZ);
    localparam logic [AW:0] DEPTH_C = BUFSZ[AW:0];

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3, S_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE = 3'd0, S_START = 3'd1, S_DATA = 3'd2, S_STOP = 3'd3
    } state_t;
`endif

    function automatic logic [3:0] clamp_bits(input logic [3:0] req);
        logic [3:0] res;
        if (req < 4'd5) begin
            res = 4'd5;
        end else if (req > 4'(DATAWIDTH)) begin
            res = 4'(DATAWIDTH);
        end else begin
            res = req;
        end
        return res;
    endfunction

    function automatic logic [DATAWIDTH-1:0] mask_word(input logic [DATAWIDTH-1:0] w,
                                                       input logic [3:0] n);
        logic [DATAWIDTH-1:0] res;
        for (int i = 0; i < DATAWIDTH; i++) begin
            res[i] = w[i] & (4'(i) < n);
        end
        return res;
    endfunction

`ifdef UART_TX_PARITY_EN
    function automatic logic even_parity(input logic [DATAWIDTH-1:0] w);
        return ^w;
    endfunction
`endif

    logic [DATAWIDTH-1:0] mem_q [BUFSZ];
    logic [AW:0]          wr_q, rd_q;
    logic [AW:0]          usage_s;
    logic                 full_s, push_ok_s, pop_s, load_s, tick_s;
    logic [DATAWIDTH-1:0] head_s, masked_s;
    logic [3:0]           nbits_s;
    logic [CW-1:0]        per_s;

    state_t               state_q, state_d;
    logic [CW-1:0]        timer_q, timer_d, per_q, per_d;
    logic [3:0]           idx_q, idx_d, nbits_q, nbits_d;
    logic                 stop2_q, stop2_d, tx_q, tx_d, busy_q, busy_d;
    logic [DATAWIDTH-1:0] shreg_q, shreg_d;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d, paren_q, paren_d;
`endif

    assign usage_s   = wr_q - rd_q;
    assign full_s    = (usage_s == DEPTH_C);
    assign push_ok_s = push_i & ~full_s;
    assign head_s    = mem_q[rd_q[AW-1:0]];
    assign nbits_s   = clamp_bits(databits_i);
    assign masked_s  = mask_word(head_s, nbits_s);
    assign per_s     = (clockcyclesperbit_i == '0) ? '0 : clockcyclesperbit_i - CW'(1);
    assign tick_s    = (timer_q == per_q);

    // FIFO storage and pointers; a push while full is dropped even if a pop happens too.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q <= '0;
            rd_q <= '0;
            for (int i = 0; i < BUFSZ; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_q[wr_q[AW-1:0]] <= data_i;
                wr_q                <= wr_q + 1'b1;
            end
            if (pop_s) begin
                rd_q <= rd_q + 1'b1;
            end
        end
    end

    // Frame sequencer next-state; tx/busy are computed one edge early and registered.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        per_d   = per_q;
        idx_d   = idx_q;
        nbits_d = nbits_q;
        stop2_d = stop2_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
        paren_d = paren_q;
`endif
        load_s  = 1'b0;
        pop_s   = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (usage_s != '0) begin
                    load_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_START: begin
                if (tick_s) begin
                    state_d = S_DATA;
                    timer_d = '0;
                    idx_d   = 4'd0;
                    tx_d    = shreg_q[0];
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
            S_DATA: begin
                if (!tick_s) begin
                    timer_d = timer_q + CW'(1);
                end else if (idx_q == nbits_q - 4'd1) begin
                    timer_d = '0;
                    idx_d   = 4'd0;
`ifdef UART_TX_PARITY_EN
                    if (paren_q) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end
`else
                    state_d = S_STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    timer_d = '0;
                    idx_d   = idx_q + 4'd1;
                    shreg_d = {1'b0, shreg_q[DATAWIDTH-1:1]};
                    tx_d    = shreg_q[1];
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (tick_s) begin
                    state_d = S_STOP;
                    timer_d = '0;
                    idx_d   = 4'd0;
                    tx_d    = 1'b1;
                end else begin
                    timer_d = timer_q + CW'(1);
                end
            end
`endif
            S_STOP: begin
                if (!tick_s) begin
                    timer_d = timer_q + CW'(1);
                end else if (idx_q == {3'b000, stop2_q}) begin
                    timer_d = '0;
                    idx_d   = 4'd0;
                    tx_d    = 1'b1;
                    if (usage_s != '0) begin
                        load_s = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    timer_d = '0;
                    idx_d   = idx_q + 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
        // Frame start: pop the head and freeze all per-frame configuration.
        if (load_s) begin
            pop_s   = 1'b1;
            state_d = S_START;
            timer_d = '0;
            idx_d   = 4'd0;
            tx_d    = 1'b0;
            per_d   = per_s;
            nbits_d = nbits_s;
            stop2_d = stop2_i;
            shreg_d = masked_s;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(masked_s) ^ parity_i[0];
            paren_d = parity_i[1];
`endif
        end else begin
            pop_s = 1'b0;
        end
        busy_d = (state_d != S_IDLE);
    end

    // Sequencer state and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            per_q   <= '0;
            idx_q   <= 4'd0;
            nbits_q <= 4'd0;
            stop2_q <= 1'b0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
            paren_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            per_q   <= per_d;
            idx_q   <= idx_d;
            nbits_q <= nbits_d;
            stop2_q <= stop2_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
            paren_q <= paren_d;
`endif
        end
    end

    assign tx_o    = tx_q;
    assign busy_o  = busy_q;
    assign usage_o = usage_s;
    assign full_o  = full_s;
endmodule

// File: tb/tb_uart_tx_multi.sv
// Self-checking bench for uart_tx_multi: per-cycle expected tx_o waveform kept in a scoreboard queue.
module tb_uart_tx_multi;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] cpb = 4'd1;
    logic [3:0] databits = 4'd8;
    logic       stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    logic [1:0] parity = 2'b00;
`endif
    logic       push = 1'b0;
    logic [8:0] data = 9'd0;
    logic       full, busy, tx;
    logic [1:0] usage;

    int total = 0;
    int bad   = 0;
    logic exp_q[$];

    uart_tx_multi #(.BUFSZ(2), .CLOCKCYCLESPERBITLIMIT(16), .DATAWIDTH(9)) dut (
        .clk_i(clk), .rst_i(rst), .clockcyclesperbit_i(cpb), .databits_i(databits),
        .stop2_i(stop2),
`ifdef UART_TX_PARITY_EN
        .parity_i(parity),
`endif
        .push_i(push), .data_i(data), .full_o(full), .usage_o(usage),
        .busy_o(busy), .tx_o(tx)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // Expected line level for every cycle of one frame; pmode 2 = even, 3 = odd, else none.
    function automatic void sb_frame(input logic [8:0] w, input int db, input bit s2,
                                     input int cyc, input int pmode);
        int n, per;
        logic p;
        logic bits[$];
        n = (db < 5) ? 5 : ((db > 9) ? 9 : db);
        per = (cyc == 0) ? 1 : cyc;
        p = 1'b0;
        bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            bits.push_back(w[i]);
            p = p ^ w[i];
        end
        if (pmode == 2) bits.push_back(p);
        if (pmode == 3) bits.push_back(~p);
        bits.push_back(1'b1);
        if (s2) bits.push_back(1'b1);
        foreach (bits[k]) begin
            for (int j = 0; j < per; j++) exp_q.push_back(bits[k]);
        end
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; push = 1'b1; data = 9'h0AA;
        @(negedge clk);
        @(negedge clk);
        push = 1'b0;
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (usage !== 2'd0) begin bad++; $display("FAIL reset_usage got=%0d want=0", usage); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b want=0", full); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int busy_cyc = 0;
        logic e;
        do_reset();
        cpb = 4'd4; databits = 4'd8; stop2 = 1'b0;
        push = 1'b1; data = 9'h055;
        sb_frame(9'h055, 8, 1'b0, 4, 0);
        @(negedge clk);
        push = 1'b0;
        total++; if (usage !== 2'd1) begin bad++; $display("FAIL basic_usage got=%0d want=1", usage); end
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL basic_latency tx=%b busy=%b want tx=1 busy=0", tx, busy); end
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (busy === 1'b1) busy_cyc++;
            total++; if (tx !== e) begin bad++; $display("FAIL basic_tx left=%0d got=%b want=%b", exp_q.size(), tx, e); end
        end
        @(negedge clk);
        if (busy === 1'b1) busy_cyc++;
        total++; if (busy_cyc !== 40) begin bad++; $display("FAIL basic_busy_len got=%0d want=40", busy_cyc); end
        total++; if (tx !== 1'b1 || usage !== 2'd0) begin bad++; $display("FAIL basic_idle tx=%b usage=%0d want 1/0", tx, usage); end
    endtask

    task automatic test_width5();
        logic e;
        do_reset();
        cpb = 4'd1; databits = 4'd5; stop2 = 1'b1;
        push = 1'b1; data = 9'h1F3;
        sb_frame(9'h1F3, 5, 1'b1, 1, 0);
        @(negedge clk);
        push = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            total++; if (tx !== e || busy !== 1'b1) begin bad++; $display("FAIL width5_tx left=%0d got=%b/%b want=%b/1", exp_q.size(), tx, busy, e); end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL width5_idle tx=%b busy=%b want 1/0", tx, busy); end
        end
    endtask

    task automatic test_back_to_back();
        logic e;
        do_reset();
        cpb = 4'd2; databits = 4'd8; stop2 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c >= 2 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (tx !== e || busy !== 1'b1) begin bad++; $display("FAIL b2b_tx c=%0d got=%b/%b want=%b/1", c, tx, busy, e); end
            end
            case (c)
                0: begin push = 1'b1; data = 9'h0A1; sb_frame(9'h0A1, 8, 1'b0, 2, 0); end
                1: begin
                    total++; if (usage !== 2'd1) begin bad++; $display("FAIL b2b_usage1 got=%0d want=1", usage); end
                    data = 9'h03C; sb_frame(9'h03C, 8, 1'b0, 2, 0);
                end
                2: begin
                    total++; if (usage !== 2'd1 || full !== 1'b0) begin bad++; $display("FAIL b2b_usage2 got=%0d/%b want=1/0", usage, full); end
                    data = 9'h0E7; sb_frame(9'h0E7, 8, 1'b0, 2, 0);
                end
                3: begin
                    total++; if (usage !== 2'd2 || full !== 1'b1) begin bad++; $display("FAIL b2b_full got=%0d/%b want=2/1", usage, full); end
                    data = 9'h000;
                end
                4: begin
                    push = 1'b0;
                    total++; if (usage !== 2'd2 || full !== 1'b1) begin bad++; $display("FAIL b2b_drop got=%0d/%b want=2/1", usage, full); end
                end
                default: push = 1'b0;
            endcase
            if (c >= 4 && exp_q.size() == 0) break;
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (tx !== 1'b1 || busy !== 1'b0 || usage !== 2'd0) begin bad++; $display("FAIL b2b_idle tx=%b busy=%b usage=%0d want 1/0/0", tx, busy, usage); end
        end
    endtask

    task automatic test_midframe_cfg();
        logic e;
        do_reset();
        cpb = 4'd1; databits = 4'd8; stop2 = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (c >= 2 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++; if (tx !== e) begin bad++; $display("FAIL cfg_tx c=%0d got=%b want=%b", c, tx, e); end
            end
            case (c)
                0: begin push = 1'b1; data = 9'h0C3; sb_frame(9'h0C3, 8, 1'b0, 1, 0); end
                1: begin data = 9'h1AD; sb_frame(9'h1AD, 6, 1'b0, 1, 0); end
                4: begin push = 1'b0; databits = 4'd6; end
                default: push = 1'b0;
            endcase
            if (c >= 4 && exp_q.size() == 0) break;
        end
        @(negedge clk);
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL cfg_idle tx=%b busy=%b want 1/0", tx, busy); end
    endtask

    task automatic test_reset_midframe();
        logic e;
        do_reset();
        cpb = 4'd2; databits = 4'd8; stop2 = 1'b0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            if (c >= 2 && c <= 6) begin
                e = exp_q.pop_front();
                total++; if (tx !== e) begin bad++; $display("FAIL rstmid_tx c=%0d got=%b want=%b", c, tx, e); end
            end
            if (c >= 8) begin
                total++; if (tx !== 1'b1 || busy !== 1'b0 || usage !== 2'd0) begin bad++; $display("FAIL rstmid_after c=%0d tx=%b busy=%b usage=%0d want 1/0/0", c, tx, busy, usage); end
            end
            case (c)
                0: begin push = 1'b1; data = 9'h0F0; sb_frame(9'h0F0, 8, 1'b0, 2, 0); end
                1: begin data = 9'h011; sb_frame(9'h011, 8, 1'b0, 2, 0); end
                2: data = 9'h022;
                3: push = 1'b0;
                6: begin
                    total++; if (usage !== 2'd2) begin bad++; $display("FAIL rstmid_queued got=%0d want=2", usage); end
                    rst = 1'b1;
                end
                7: begin
                    total++; if (tx !== 1'b1 || usage !== 2'd0 || busy !== 1'b0 || full !== 1'b0) begin bad++; $display("FAIL rstmid_edge tx=%b usage=%0d busy=%b full=%b want 1/0/0/0", tx, usage, busy, full); end
                    rst = 1'b0;
                    exp_q.delete();
                end
                default: push = 1'b0;
            endcase
        end
    endtask

    task automatic test_cpb0();
        int busy_cyc = 0;
        logic e;
        do_reset();
        cpb = 4'd0; databits = 4'd8; stop2 = 1'b0;
        push = 1'b1; data = 9'h0A5;
        sb_frame(9'h0A5, 8, 1'b0, 0, 0);
        @(negedge clk);
        push = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (busy === 1'b1) busy_cyc++;
            total++; if (tx !== e) begin bad++; $display("FAIL cpb0_tx left=%0d got=%b want=%b", exp_q.size(), tx, e); end
        end
        @(negedge clk);
        total++; if (busy_cyc !== 10 || busy !== 1'b0) begin bad++; $display("FAIL cpb0_len got=%0d busy=%b want=10/0", busy_cyc, busy); end
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic e;
        for (int m = 2; m <= 3; m++) begin
            do_reset();
            cpb = 4'd1; databits = 4'd8; stop2 = 1'b0; parity = 2'(m);
            push = 1'b1; data = 9'h007;
            sb_frame(9'h007, 8, 1'b0, 1, m);
            @(negedge clk);
            push = 1'b0;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                e = exp_q.pop_front();
                total++; if (tx !== e) begin bad++; $display("FAIL parity_tx mode=%0d left=%0d got=%b want=%b", m, exp_q.size(), tx, e); end
            end
            @(negedge clk);
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL parity_idle mode=%0d busy=%b want=0", m, busy); end
        end
        parity = 2'b00;
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_width5();
        test_back_to_back();
        test_midframe_cfg();
        test_reset_midframe();
        test_cpb0();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
